gpio_stream_reader: RTL and testbench
=====================================

GPIO_STREAM_READER -- requirements
Module: gpio_stream_reader

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of AXI-stream readback channels (1..16).
REQ-002 SHALL have parameter CH_WIDTH, default 128: data width of each channel in bits.
REQ-003 SHALL have parameter SLICE_W, default 16: bits returned per GPIO read (1..31).
REQ-004 SHALL have parameter NUM_STAT, default 4: number of 32-bit status words (1..16).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on posedge clk.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port gpio_in, input, 32: CPU GPIO word carrying the w_clk strobe and the address field; synchronous to clk.
REQ-008 SHALL have port gpio_out, output, 32: readback word to the CPU.
REQ-009 SHALL have port valid, output, 1: read-success flag, mirrored into gpio_out[31] on channel reads.
REQ-010 SHALL have port ch_data, input, NUM_CH*CH_WIDTH: channel k occupies bits [k*CH_WIDTH +: CH_WIDTH].
REQ-011 SHALL have port ch_valid, input, NUM_CH: per-channel AXIS valid.
REQ-012 SHALL have port ch_ready, output, NUM_CH: per-channel AXIS ready.
REQ-013 SHALL have port stat_in, input, NUM_STAT*32: status words, passed through to the CPU.

Function
REQ-014 SHALL decode w_clk as gpio_in[gpio_w_clk_bit] and addr as gpio_in[gpio_addr_start:gpio_addr_end].
REQ-015 SHALL map channel reads to addr RD_BASE+k, status reads to STAT_BASE+i, and the rewind command to REWIND_REG.
REQ-016 SHALL treat any other addr as unmapped: gpio_out=0, valid=1.
REQ-017 SHALL split each channel word into NSLICE=ceil(CH_WIDTH/SLICE_W) slices, least significant first.
REQ-018 SHALL zero-pad the last slice above CH_WIDTH, and zero-extend every slice to 31 bits.
REQ-019 SHALL run a state machine with two states, IDLE and HOLD, and hold a per-channel slice counter cnt[k] of width max(1,clog2(NSLICE)).
REQ-020 SHALL evaluate, in IDLE with w_clk=1 and addr=RD_BASE+k with ch_valid[k]=1: rd_reg<=slice cnt[k], rd_valid<=1.
REQ-021 SHALL, in the same case, advance cnt[k], wrapping to 0 after NSLICE-1.
REQ-022 SHALL, in the same case when cnt[k]==NSLICE-1, pulse ch_ready[k] for exactly one cycle.
REQ-023 SHALL, in IDLE with w_clk=1 and addr=RD_BASE+k with ch_valid[k]=0, set rd_valid<=0, leave rd_reg and cnt[k] unchanged, and raise no ready.
REQ-024 SHALL, in IDLE with w_clk=1 and addr=REWIND_REG, clear all cnt[] to 0 and raise no ready (the rest of the current stream word is skipped on the next reads).
REQ-025 SHALL move every w_clk=1 in IDLE, whatever the addr, to HOLD on the next cycle.
REQ-026 SHALL, in HOLD, force all ch_ready to 0 and keep rd_valid and rd_reg.
REQ-027 SHALL, in HOLD with w_clk=0, return to IDLE and clear rd_valid.
REQ-028 SHALL therefore accept one read per w_clk high pulse, however long the pulse.
REQ-029 SHALL drive, on a channel-read addr, gpio_out={valid, rd_reg[30:0]} with valid=rd_valid, combinationally from the current addr.
REQ-030 SHALL drive, on a status addr, gpio_out=stat_in word i with valid=1.
REQ-031 SHALL use the ch_valid and ch_data values present in the strobe cycle; a ch_valid fall in that same cycle means a failed read.
REQ-032 SHALL give first-read latency of one clk from w_clk rising to valid data on gpio_out.

Reset
REQ-033 SHALL, on rst=1, set: state=HOLD, rd_valid=0, rd_reg=0, all cnt=0, all ch_ready=0.
REQ-034 SHALL, because of the HOLD entry, ignore a w_clk still high after reset until it is seen low (no phantom read).
REQ-035 SHALL discard a reset taken mid-word: the partly-read stream word stays un-popped and is read from slice 0 again.

Configuration
REQ-036 SHALL, with UNDERFLOW_CNT_EN defined, keep a 16-bit saturating count per channel of failed reads (REQ-023).
REQ-037 SHALL, with UNDERFLOW_CNT_EN defined, make each count readable at UFLOW_BASE+k and clear it by reset.
REQ-038 SHALL, without UNDERFLOW_CNT_EN, build no counters and treat UFLOW_BASE+k as unmapped.

Structure
REQ-039 SHALL take gpio_w_clk_bit, gpio_addr_start, gpio_addr_end, gpio_addr_width, RD_BASE, STAT_BASE, UFLOW_BASE and REWIND_REG from package ising_config.
REQ-040 SHALL take the state enum from ising_config too.
REQ-041 SHALL put the per-channel slice counter, slice mux and underflow counter in one sub-module, gpio_slice_chan, generated NUM_CH times.

Verification
REQ-042 SHALL check: NUM_CH=2, CH_WIDTH=128, SLICE_W=16, ch0 data 0x0F0E..0100 with valid=1, 8 pulses on RD_BASE+0 -> reads 0x8000_0100 .. 0x8000_0F0E; a single ch_ready[0] pulse only on the 8th pulse.
REQ-043 SHALL check: CH_WIDTH=40, SLICE_W=16 -> 3 slices, the third zero-padded (data 0xAB_1234_5678 -> 0x5678, 0x1234, 0x00AB); ready on the 3rd read.
REQ-044 SHALL check: ch1 valid=0 with one pulse on RD_BASE+1 -> gpio_out[31]=0, cnt unchanged, ch_ready=0, and underflow count =1 when UNDERFLOW_CNT_EN is defined.
REQ-045 SHALL check: a w_clk held high 50 cycles -> exactly one slice consumed.
REQ-046 SHALL check: rst asserted with w_clk=1 after 3 reads -> no read until w_clk drops, next read returns slice 0 of the same word.
REQ-047 SHALL check: rewind after 2 slices -> next read is slice 0; stat_in word 2=0xDEADBEEF read at STAT_BASE+2 -> 0xDEADBEEF.

Source files
------------

// File: rtl/ising_config.sv
// ising_config: GPIO field positions, readback address map and reader state encoding.
package ising_config;
  localparam int gpio_w_clk_bit = 31;
  localparam int gpio_addr_start = 7;
  localparam int gpio_addr_end = 0;
  localparam int gpio_addr_width = gpio_addr_start - gpio_addr_end + 1;
  localparam logic [gpio_addr_width-1:0] RD_BASE = 'h00;
  localparam logic [gpio_addr_width-1:0] STAT_BASE = 'h20;
  localparam logic [gpio_addr_width-1:0] UFLOW_BASE = 'h40;
  localparam logic [gpio_addr_width-1:0] REWIND_REG = 'h7F;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/gpio_slice_chan.sv
// gpio_slice_chan: per-channel slice counter and slice mux; UNDERFLOW_CNT_EN adds a saturating failed-read counter.
module gpio_slice_chan #(
  parameter int CH_WIDTH = 128,
  parameter int SLICE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd,
  input  logic                rewind,
`ifdef UNDERFLOW_CNT_EN
  input  logic                fail,
  output logic [15:0]         uflow,
`endif
  input  logic [CH_WIDTH-1:0] data,
  output logic [30:0]         slice,
  output logic                last
);
  localparam int NSLICE = (CH_WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam int PW = NSLICE * SLICE_W;
  logic [CW-1:0] cnt;
  logic [PW-1:0] padded;
  assign padded = PW'(data);
  assign slice = 31'(padded[32'(cnt)*SLICE_W +: SLICE_W]);
  assign last = cnt == CW'(NSLICE - 1);
  always_ff @(posedge clk)
    if (rst || rewind) cnt <= '0;
    else if (rd) cnt <= last ? '0 : cnt + 1'b1;
`ifdef UNDERFLOW_CNT_EN
  always_ff @(posedge clk)
    if (rst) uflow <= '0;
    else if (fail && uflow != 16'hFFFF) uflow <= uflow + 1'b1;
`endif
endmodule

// File: rtl/gpio_stream_reader.sv
// gpio_stream_reader: CPU reads AXI-stream channels slice by slice over a GPIO strobe/address word.
// Define UNDERFLOW_CNT_EN to add per-channel failed-read counters at UFLOW_BASE+k.
module gpio_stream_reader
  import ising_config::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_WIDTH = 128,
  parameter int SLICE_W = 16,
  parameter int NUM_STAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                gpio_in,
  output logic [31:0]                gpio_out,
  output logic                       valid,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_STAT*32-1:0]     stat_in
);
  localparam int AW = gpio_addr_width;
  state_t state, state_n;
  logic w_clk, strobe, rewind, rd_valid, unused_gpio;
  logic [AW-1:0] addr;
  logic [30:0] rd_reg, rd_sel;
  logic [NUM_CH-1:0] sel, rd, last;
  logic [30:0] slice [NUM_CH];
`ifdef UNDERFLOW_CNT_EN
  logic [15:0] uflow [NUM_CH];
`endif
  assign w_clk = gpio_in[gpio_w_clk_bit];
  assign addr = gpio_in[gpio_addr_start:gpio_addr_end];
  assign unused_gpio = ^gpio_in;
  // only the first cycle of a w_clk pulse in IDLE counts as a read
  assign strobe = !rst && state == IDLE && w_clk;
  assign rewind = strobe && addr == REWIND_REG;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel[k] = addr == AW'(RD_BASE + k);
    assign rd[k] = strobe && sel[k] && ch_valid[k];
    assign ch_ready[k] = rd[k] && last[k];
    gpio_slice_chan #(.CH_WIDTH(CH_WIDTH), .SLICE_W(SLICE_W)) u_chan (
      .clk(clk),
      .rst(rst),
      .rd(rd[k]),
      .rewind(rewind),
`ifdef UNDERFLOW_CNT_EN
      .fail(strobe && sel[k] && !ch_valid[k]),
      .uflow(uflow[k]),
`endif
      .data(ch_data[k*CH_WIDTH +: CH_WIDTH]),
      .slice(slice[k]),
      .last(last[k])
    );
  end
  always_comb state_n = w_clk ? HOLD : IDLE;
  always_comb begin
    rd_sel = rd_reg;
    for (int i = 0; i < NUM_CH; i++) if (sel[i]) rd_sel = slice[i];
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= HOLD;
      rd_valid <= 1'b0;
      rd_reg <= '0;
    end else begin
      state <= state_n;
      if (strobe && |sel) begin
        rd_valid <= |rd;
        rd_reg <= |rd ? rd_sel : rd_reg;
      end else if (state == HOLD && !w_clk) rd_valid <= 1'b0;
    end
  always_comb begin
    gpio_out = '0;
    valid = 1'b1;
    for (int i = 0; i < NUM_STAT; i++) if (addr == AW'(STAT_BASE + i)) gpio_out = stat_in[i*32 +: 32];
`ifdef UNDERFLOW_CNT_EN
    for (int i = 0; i < NUM_CH; i++) if (addr == AW'(UFLOW_BASE + i)) gpio_out = {16'h0, uflow[i]};
`endif
    for (int i = 0; i < NUM_CH; i++)
      if (addr == AW'(RD_BASE + i)) begin
        gpio_out = {rd_valid, rd_reg};
        valid = rd_valid;
      end
  end
endmodule

// File: tb/tb_gpio_stream_reader.sv
// tb_gpio_stream_reader: vector table plus hand sequences for hold, rewind and reset corner cases.
module tb_gpio_stream_reader;
  import ising_config::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] gpio_in = '0, gpio_in2 = '0, gpio_out, gpio_out2;
  logic valid, valid2;
  logic [255:0] ch_data;
  logic [1:0] ch_valid, ch_ready;
  logic [39:0] ch_data2;
  logic ch_valid2, ch_ready2;
  logic [127:0] stat_in;
  logic [31:0] stat_in2;
  int checks = 0, errors = 0, rdy_pulses = 0, r0;
  always #5 clk = ~clk;

  gpio_stream_reader #(.NUM_CH(2), .CH_WIDTH(128), .SLICE_W(16), .NUM_STAT(4)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out(gpio_out), .valid(valid),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready), .stat_in(stat_in));
  gpio_stream_reader #(.NUM_CH(1), .CH_WIDTH(40), .SLICE_W(16), .NUM_STAT(1)) dut40 (
    .clk(clk), .rst(rst), .gpio_in(gpio_in2), .gpio_out(gpio_out2), .valid(valid2),
    .ch_data(ch_data2), .ch_valid(ch_valid2), .ch_ready(ch_ready2), .stat_in(stat_in2));

  typedef struct {logic [7:0] a; logic [31:0] out; logic v; logic [1:0] rdy; string name;} vec_t;
  vec_t sb[$];
  vec_t tbl[13];

  always @(negedge clk) begin
    #2;
    if (ch_ready[0]) rdy_pulses++;
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic pulse(bit d40, vec_t e);
    vec_t x;
    logic [1:0] rdy;
    sb.push_back(e);
    @(negedge clk);
    if (d40) gpio_in2 = {1'b1, 23'b0, e.a};
    else gpio_in = {1'b1, 23'b0, e.a};
    #2 rdy = d40 ? {1'b0, ch_ready2} : ch_ready;
    @(negedge clk);
    #1 x = sb.pop_front();
    chk({x.name, " out"}, d40 ? gpio_out2 : gpio_out, x.out);
    chk({x.name, " valid"}, 32'(d40 ? valid2 : valid), 32'(x.v));
    chk({x.name, " ready"}, 32'(rdy), 32'(x.rdy));
    if (d40) gpio_in2[31] = 1'b0;
    else gpio_in[31] = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe_only(logic [7:0] a);
    @(negedge clk);
    gpio_in = {1'b1, 23'b0, a};
    @(negedge clk);
    gpio_in[31] = 1'b0;
    @(negedge clk);
  endtask

  function automatic vec_t rd0(logic [31:0] out, logic [1:0] rdy, string name);
    return '{RD_BASE, out, 1'b1, rdy, name};
  endfunction

  initial begin
    ch_data = {128'h0000_0000_0000_0000_0000_0000_0000_BEEF, 128'h0F0E0D0C0B0A09080706050403020100};
    ch_valid = 2'b01;
    stat_in = {32'h0, 32'hDEADBEEF, 32'h1111_2222, 32'h0};
    ch_data2 = 40'hAB_1234_5678;
    ch_valid2 = 1'b1;
    stat_in2 = '0;
    for (int i = 0; i < 8; i++)
      tbl[i] = rd0(32'h8000_0000 | ((2 * i + 1) << 8) | (2 * i), i == 7 ? 2'b01 : 2'b00, $sformatf("ch0 slice%0d", i));
    tbl[8] = '{8'(RD_BASE + 1), 32'h0000_0F0E, 1'b0, 2'b00, "ch1 empty"};
    tbl[9] = '{8'(STAT_BASE + 2), 32'hDEADBEEF, 1'b1, 2'b00, "stat2"};
    tbl[10] = '{8'h10, 32'h0, 1'b1, 2'b00, "unmapped"};
`ifdef UNDERFLOW_CNT_EN
    tbl[11] = '{8'(UFLOW_BASE + 1), 32'h1, 1'b1, 2'b00, "uflow1"};
`else
    tbl[11] = '{8'(UFLOW_BASE + 1), 32'h0, 1'b1, 2'b00, "uflow1 unmapped"};
`endif
    tbl[12] = rd0(32'h8000_0100, 2'b00, "ch0 wrap");

    gpio_in = {24'b0, RD_BASE};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("reset out", gpio_out, 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset ready", 32'(ch_ready), 32'h0);

    pulse(1'b1, rd0(32'h8000_5678, 2'b00, "w40 s0"));
    pulse(1'b1, rd0(32'h8000_1234, 2'b00, "w40 s1"));
    pulse(1'b1, rd0(32'h8000_00AB, 2'b01, "w40 s2"));

    r0 = rdy_pulses;
    for (int i = 0; i < 13; i++) pulse(1'b0, tbl[i]);
    chk("ch0 ready pulses", 32'(rdy_pulses - r0), 32'd1);

    ch_valid = 2'b11;
    pulse(1'b0, '{8'(RD_BASE + 1), 32'h8000_BEEF, 1'b1, 2'b00, "ch1 cnt kept"});

    r0 = rdy_pulses;
    @(negedge clk);
    gpio_in = {1'b1, 23'b0, RD_BASE};
    repeat (50) @(negedge clk);
    #1 chk("hold out", gpio_out, 32'h8000_0302);
    gpio_in[31] = 1'b0;
    @(negedge clk);
    chk("hold ready", 32'(rdy_pulses - r0), 32'h0);
    pulse(1'b0, rd0(32'h8000_0504, 2'b00, "after hold"));

    strobe_only(REWIND_REG);
    pulse(1'b0, rd0(32'h8000_0100, 2'b00, "rewind a s0"));
    pulse(1'b0, rd0(32'h8000_0302, 2'b00, "rewind a s1"));
    strobe_only(REWIND_REG);
    pulse(1'b0, rd0(32'h8000_0100, 2'b00, "rewind b s0"));
    pulse(1'b0, rd0(32'h8000_0302, 2'b00, "pre-rst s1"));
    pulse(1'b0, rd0(32'h8000_0504, 2'b00, "pre-rst s2"));

    r0 = rdy_pulses;
    @(negedge clk);
    gpio_in = {1'b1, 23'b0, RD_BASE};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("no phantom out", gpio_out, 32'h0);
    chk("no phantom valid", 32'(valid), 32'h0);
    gpio_in[31] = 1'b0;
    @(negedge clk);
    chk("rst ready", 32'(rdy_pulses - r0), 32'h0);
    pulse(1'b0, '{8'(UFLOW_BASE + 1), 32'h0, 1'b1, 2'b00, "uflow after rst"});
    pulse(1'b0, rd0(32'h8000_0100, 2'b00, "after rst s0"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
